// File: rtl/plot_pkg.sv
// ---------------------------------------------------------------------------
// plot_pkg
// Shared constants and types for the pixel-plot write queue.
//   IMAGE_WIDTH / IMAGE_HEIGHT : visible raster geometry
//   COLOR_BITS                 : colour width of one pixel
//   ADDR_W                     : linear frame-memory address width
//   X_W / Y_W                  : CPU coordinate widths
//   LEVEL_W / DROP_W           : status counter widths
//   plot_entry_t               : one queued write {addr, color}
//   pixel_addr()               : row-major linear address y*width + x
// ---------------------------------------------------------------------------
package plot_pkg;

  localparam int IMAGE_WIDTH  = 320;
  localparam int IMAGE_HEIGHT = 240;
  localparam int COLOR_BITS   = 3;
  localparam int ADDR_W       = 17;
  localparam int X_W          = 9;
  localparam int Y_W          = 8;
  localparam int LEVEL_W      = 5;
  localparam int DROP_W       = 8;

  // One queued frame-memory write; addr occupies the upper bits.
  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [COLOR_BITS-1:0] color;
  } plot_entry_t;

  // Row-major address. Every operand is widened to ADDR_W before the
  // multiply so 255*320+511 (82111) is representable without truncation.
  function automatic logic [ADDR_W-1:0] pixel_addr(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y,
    input int unsigned    width
  );
    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] w_ext;
    x_ext = {{(ADDR_W-X_W){1'b0}}, x};
    y_ext = {{(ADDR_W-Y_W){1'b0}}, y};
    w_ext = ADDR_W'(width);
    return (y_ext * w_ext) + x_ext;
  endfunction

endpackage

// File: rtl/plot_write_queue_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO used as the plot write queue storage.
// Parameters:
//   Width  : entry width in bits
//   Depth  : number of entries (power of two, 2..16)
//   LevelW : width of the level output (must hold Depth)
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-low reset (clears pointers and level)
//   push   in   write din this cycle (ignored when full)
//   pop    in   retire the head this cycle (ignored when empty)
//   din    in   entry to write
//   dout   out  current head entry (undefined contents when empty)
//   level  out  number of stored entries
//   full   out  level == Depth
//   empty  out  level == 0
// A full FIFO refuses a push even when a pop happens in the same cycle,
// so there is no combinational path from pop to the accept decision.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int Width  = 20,
  parameter int Depth  = 8,
  parameter int LevelW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [Width-1:0]  din,
  output logic [Width-1:0]  dout,
  output logic [LevelW-1:0] level,
  output logic              full,
  output logic              empty
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]  mem_r [Depth];
  logic [PtrW-1:0]   wr_ptr_r;
  logic [PtrW-1:0]   rd_ptr_r;
  logic [LevelW-1:0] level_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  assign full_s  = (level_r == LevelW'(Depth));
  assign empty_s = (level_r == {LevelW{1'b0}});
  assign push_s  = push && !full_s;
  assign pop_s   = pop && !empty_s;

  // Storage array: written on accepted push, no reset needed since the
  // empty flag gates every consumer of the head entry.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and level; pointers wrap naturally because Depth is 2**PtrW.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      level_r  <= {LevelW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PtrW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LevelW'(1);
        2'b01:   level_r <= level_r - LevelW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign level = level_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/plot_write_queue.sv
// ---------------------------------------------------------------------------
// plot_write_queue
// Decouples CPU pixel-plot requests from a frame memory that may stall.
// Each accepted request is converted to a linear address (y*ImageWidth + x)
// at push time and queued with its colour; the head of the queue is
// presented show-ahead on the memory write port.
//
// Build option:
//   PLOT_BOUNDS_CHECK_EN - when defined, requests with x >= ImageWidth or
//     y >= ImageHeight still complete the handshake but are not queued,
//     and drop_count counts them (saturating at 255). When undefined,
//     every accepted request is queued and drop_count is held at 0.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-low reset
//   plot_valid  in   CPU pixel-write request
//   plot_ready  out  queue can accept a request this cycle
//   plot_x      in   pixel column (9 bits)
//   plot_y      in   pixel row (8 bits)
//   plot_color  in   pixel colour
//   mem_we      out  frame-memory write strobe (queue non-empty)
//   mem_addr    out  head entry address, 0 when empty
//   mem_data    out  head entry colour, 0 when empty
//   mem_ready   in   frame memory takes the write this cycle
//   fifo_level  out  number of queued entries
//   drop_count  out  out-of-range requests discarded
// ---------------------------------------------------------------------------
module plot_write_queue
  import plot_pkg::*;
#(
  parameter int ImageWidth  = IMAGE_WIDTH,
  parameter int ImageHeight = IMAGE_HEIGHT,
  parameter int ColorBits   = COLOR_BITS,
  parameter int Depth       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 plot_valid,
  output logic                 plot_ready,
  input  logic [X_W-1:0]       plot_x,
  input  logic [Y_W-1:0]       plot_y,
  input  logic [ColorBits-1:0] plot_color,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [ColorBits-1:0] mem_data,
  input  logic                 mem_ready,
  output logic [LEVEL_W-1:0]   fifo_level,
  output logic [DROP_W-1:0]    drop_count
);

  localparam int EntryW = ADDR_W + ColorBits;

  // Geometry and depth sanity: catch illegal configurations at elaboration.
  if ((ImageWidth * ImageHeight) > (32'd1 << ADDR_W)) begin : g_bad_geometry
    $error("plot_write_queue: frame does not fit in the address width");
  end
  if ((Depth < 2) || (Depth > 16) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
    $error("plot_write_queue: Depth must be a power of two in 2..16");
  end

  logic                 accept_s;
  logic                 push_s;
  logic                 pop_s;
  logic [EntryW-1:0]    push_entry_s;
  logic [EntryW-1:0]    head_entry_s;
  logic [LEVEL_W-1:0]   level_s;
  logic                 full_s;
  logic                 empty_s;
  logic [ADDR_W-1:0]    req_addr_s;

  assign plot_ready = !full_s;
  assign accept_s   = plot_valid && !full_s;
  assign req_addr_s = pixel_addr(plot_x, plot_y, ImageWidth);
  assign push_entry_s = {req_addr_s, plot_color};
  assign pop_s      = !empty_s && mem_ready;

`ifdef PLOT_BOUNDS_CHECK_EN
  logic              in_range_s;
  logic [DROP_W-1:0] drop_r;

  assign in_range_s = ({{(32-X_W){1'b0}}, plot_x} < 32'(ImageWidth)) &&
                      ({{(32-Y_W){1'b0}}, plot_y} < 32'(ImageHeight));
  assign push_s     = accept_s && in_range_s;

  // Count out-of-range requests that completed the handshake, saturating.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_r <= {DROP_W{1'b0}};
    end else if (accept_s && !in_range_s && (drop_r != {DROP_W{1'b1}})) begin
      drop_r <= drop_r + DROP_W'(1);
    end else begin
      drop_r <= drop_r;
    end
  end

  assign drop_count = drop_r;
`else
  assign push_s     = accept_s;
  assign drop_count = {DROP_W{1'b0}};
`endif

  sync_fifo #(
    .Width  (EntryW),
    .Depth  (Depth),
    .LevelW (LEVEL_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .dout  (head_entry_s),
    .level (level_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Memory port: head entry when non-empty, forced to zero when empty so
  // stale array contents never appear on the bus.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = {ADDR_W{1'b0}};
    mem_data = {ColorBits{1'b0}};
    if (!empty_s) begin
      mem_we   = 1'b1;
      mem_addr = head_entry_s[EntryW-1:ColorBits];
      mem_data = head_entry_s[ColorBits-1:0];
    end else begin
      mem_we   = 1'b0;
      mem_addr = {ADDR_W{1'b0}};
      mem_data = {ColorBits{1'b0}};
    end
  end

  assign fifo_level = level_s;

endmodule

// File: tb/tb_plot_write_queue.sv
// Directed self-checking bench for plot_write_queue. Inputs change 1 ns
// after a rising edge and outputs are checked at that same point, well
// away from the next active edge.
module tb_plot_write_queue;

  logic        clk;
  logic        reset;
  logic        plot_valid;
  logic        plot_ready;
  logic [8:0]  plot_x;
  logic [7:0]  plot_y;
  logic [2:0]  plot_color;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_ready;
  logic [4:0]  fifo_level;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;

  // Hand-computed vectors for the backpressure burst: addr = y*320 + x.
  logic [8:0]  bx [9];
  logic [7:0]  by [9];
  logic [2:0]  bc [9];
  logic [16:0] ba [9];

  plot_write_queue dut (
    .clk        (clk),
    .reset      (reset),
    .plot_valid (plot_valid),
    .plot_ready (plot_ready),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_color (plot_color),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
    plot_valid = 1'b1;
    plot_x     = x;
    plot_y     = y;
    plot_color = c;
  endtask

  initial begin
    bx[0] = 9'd0;   by[0] = 8'd0;   bc[0] = 3'd0; ba[0] = 17'd0;
    bx[1] = 9'd1;   by[1] = 8'd0;   bc[1] = 3'd1; ba[1] = 17'd1;
    bx[2] = 9'd10;  by[2] = 8'd1;   bc[2] = 3'd2; ba[2] = 17'd330;
    bx[3] = 9'd319; by[3] = 8'd0;   bc[3] = 3'd3; ba[3] = 17'd319;
    bx[4] = 9'd0;   by[4] = 8'd100; bc[4] = 3'd4; ba[4] = 17'd32000;
    bx[5] = 9'd7;   by[5] = 8'd3;   bc[5] = 3'd5; ba[5] = 17'd967;
    bx[6] = 9'd200; by[6] = 8'd50;  bc[6] = 3'd6; ba[6] = 17'd16200;
    bx[7] = 9'd100; by[7] = 8'd239; bc[7] = 3'd7; ba[7] = 17'd76580;
    bx[8] = 9'd50;  by[8] = 8'd50;  bc[8] = 3'd1; ba[8] = 17'd16050;

    // Reset with a request presented: the request must be discarded.
    reset = 1'b0; mem_ready = 1'b0;
    req(9'd5, 8'd5, 3'd3);
    tick(); tick();
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_we",    32'(mem_we),     32'd0);
    check_eq("rst_addr",  32'(mem_addr),   32'd0);
    check_eq("rst_data",  32'(mem_data),   32'd0);
    check_eq("rst_drop",  32'(drop_count), 32'd0);
    reset = 1'b1; plot_valid = 1'b0;
    check_eq("rst_ready", 32'(plot_ready), 32'd1);
    tick();
    check_eq("rst_no_ghost", 32'(mem_we), 32'd0);

    // Single write, one-cycle latency, then popped.
    mem_ready = 1'b1;
    req(9'd5, 8'd2, 3'b101);
    check_eq("single_ready", 32'(plot_ready), 32'd1);
    tick();
    plot_valid = 1'b0;
    check_eq("single_we",    32'(mem_we),     32'd1);
    check_eq("single_addr",  32'(mem_addr),   32'd645);
    check_eq("single_data",  32'(mem_data),   32'd5);
    check_eq("single_level", 32'(fifo_level), 32'd1);
    tick();
    check_eq("single_empty", 32'(fifo_level), 32'd0);
    check_eq("single_we0",   32'(mem_we),     32'd0);
    check_eq("single_addr0", 32'(mem_addr),   32'd0);

    // Corner address.
    req(9'd319, 8'd239, 3'd7);
    tick();
    plot_valid = 1'b0;
    check_eq("corner_addr", 32'(mem_addr), 32'd76799);
    check_eq("corner_data", 32'(mem_data), 32'd7);
    tick();

`ifdef PLOT_BOUNDS_CHECK_EN
    // Out-of-range requests handshake but are not queued.
    req(9'd320, 8'd0, 3'd1);
    check_eq("oob_ready1", 32'(plot_ready), 32'd1);
    tick();
    check_eq("oob_we1", 32'(mem_we), 32'd0);
    req(9'd0, 8'd240, 3'd2);
    check_eq("oob_ready2", 32'(plot_ready), 32'd1);
    tick();
    plot_valid = 1'b0;
    check_eq("oob_we2",    32'(mem_we),     32'd0);
    check_eq("oob_level",  32'(fifo_level), 32'd0);
    check_eq("oob_drop2",  32'(drop_count), 32'd2);
    req(9'd400, 8'd10, 3'd0);
    for (int i = 0; i < 300; i++) tick();
    plot_valid = 1'b0;
    check_eq("oob_drop_sat", 32'(drop_count), 32'd255);
`else
    // Unchecked build: out-of-range coordinates are queued as computed.
    req(9'd320, 8'd0, 3'd1);
    tick();
    plot_valid = 1'b0;
    check_eq("nochk_addr320", 32'(mem_addr), 32'd320);
    tick();
    req(9'd511, 8'd255, 3'd6);
    tick();
    plot_valid = 1'b0;
    check_eq("nochk_addrmax", 32'(mem_addr),   32'd82111);
    check_eq("nochk_drop",    32'(drop_count), 32'd0);
    tick();
`endif

    // Simultaneous push and pop at level 1 keeps the level constant.
    req(9'd2, 8'd0, 3'd1);
    tick();
    check_eq("pp_level_a", 32'(fifo_level), 32'd1);
    check_eq("pp_addr_a",  32'(mem_addr),   32'd2);
    req(9'd3, 8'd0, 3'd2);
    tick();
    check_eq("pp_level_b", 32'(fifo_level), 32'd1);
    check_eq("pp_addr_b",  32'(mem_addr),   32'd3);
    req(9'd0, 8'd1, 3'd3);
    tick();
    plot_valid = 1'b0;
    check_eq("pp_level_c", 32'(fifo_level), 32'd1);
    check_eq("pp_addr_c",  32'(mem_addr),   32'd320);
    tick();
    check_eq("pp_drained", 32'(fifo_level), 32'd0);

    // Backpressure: 9 back-to-back requests, only 8 fit.
    mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      req(bx[i], by[i], bc[i]);
      check_eq($sformatf("bp_ready_%0d", i), 32'(plot_ready), (i < 8) ? 32'd1 : 32'd0);
      tick();
    end
    check_eq("bp_level8",  32'(fifo_level), 32'd8);
    check_eq("bp_ready0",  32'(plot_ready), 32'd0);
    check_eq("bp_we",      32'(mem_we),     32'd1);
    check_eq("bp_hold",    32'(mem_addr),   32'(ba[0]));
    // Full queue with push and pop together: push refused, level drops.
    mem_ready = 1'b1;
    tick();
    plot_valid = 1'b0;
    check_eq("full_pp_level", 32'(fifo_level), 32'd7);
    check_eq("full_pp_ready", 32'(plot_ready), 32'd1);
    for (int i = 1; i < 8; i++) begin
      check_eq($sformatf("bp_addr_%0d", i), 32'(mem_addr), 32'(ba[i]));
      check_eq($sformatf("bp_data_%0d", i), 32'(mem_data), 32'(bc[i]));
      tick();
    end
    check_eq("bp_empty", 32'(fifo_level), 32'd0);
    check_eq("bp_we0",   32'(mem_we),     32'd0);

    // Reset with 5 entries queued and memory stalled.
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req(bx[i], by[i], bc[i]);
      tick();
    end
    plot_valid = 1'b0;
    check_eq("rst5_level_pre", 32'(fifo_level), 32'd5);
    reset = 1'b0;
    req(9'd9, 8'd9, 3'd2);
    tick();
    check_eq("rst5_level", 32'(fifo_level), 32'd0);
    check_eq("rst5_we",    32'(mem_we),     32'd0);
    check_eq("rst5_addr",  32'(mem_addr),   32'd0);
    check_eq("rst5_drop",  32'(drop_count), 32'd0);
    reset = 1'b1;
    plot_valid = 1'b0;
    check_eq("rst5_ready", 32'(plot_ready), 32'd1);
    tick();
    check_eq("rst5_still_empty", 32'(fifo_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
